param_issue_queue: RTL and testbench

//  Parametrised collapsing instruction queue; successor to the fixed 2-in/4-out queue with its separate entry-select, shift and address blocks.

---
 rtl/param_issue_queue.sv | 153 +++++++++++++++
 tb/tb_param_issue_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/param_issue_queue.sv
// Collapsing issue queue: DISP_W dispatch lanes in, the ISSUE_W oldest entries presented combinationally.
// Dispatched entries are visible one cycle later; in_rdy falls when DISP_W slots are not free, all tags are live, or a flush is in progress.
module param_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int DISP_W  = 2,
  parameter int ISSUE_W = 4,
  parameter int REG_W   = 5,
  parameter int OP_W    = 4,
  parameter int IMM_W   = 16,
  parameter int NBR     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DISP_W-1:0]            in_vld,
  input  logic [DISP_W*REG_W-1:0]      in_des,
  input  logic [DISP_W*REG_W-1:0]      in_s1,
  input  logic [DISP_W*REG_W-1:0]      in_s2,
  input  logic [DISP_W*OP_W-1:0]       in_op,
  input  logic [DISP_W*IMM_W-1:0]      in_ime,
  input  logic [DISP_W-1:0]            in_br,
  input  logic [DISP_W*NBR-1:0]        in_br_tag,
  output logic                         in_rdy,
  output logic [ISSUE_W-1:0]           out_vld,
  output logic [ISSUE_W*REG_W-1:0]     out_des,
  output logic [ISSUE_W*REG_W-1:0]     out_s1,
  output logic [ISSUE_W*REG_W-1:0]     out_s2,
  output logic [ISSUE_W*OP_W-1:0]      out_op,
  output logic [ISSUE_W*IMM_W-1:0]     out_ime,
  output logic [ISSUE_W-1:0]           out_branch,
  output logic [ISSUE_W*NBR-1:0]       out_br_mask,
  input  logic [ISSUE_W-1:0]           out_gnt,
  input  logic                         resolve_en,
  input  logic [NBR-1:0]               resolve_id,
  input  logic                         flush_en,
  input  logic [NBR-1:0]               flush_mask,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         entry_full,
  output logic                         entry_empty,
  output logic                         branch_full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM_C  = CW'(DEPTH - DISP_W);

  typedef struct packed {
    logic [REG_W-1:0] des;
    logic [REG_W-1:0] s1;
    logic [REG_W-1:0] s2;
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] ime;
    logic             br;
    logic [NBR-1:0]   mask;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            nw;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  kill, gnt_hit, gnt_ext;
  logic [NBR-1:0]    live_q, live_d;
  logic [NBR-1:0]    clr, run_mask, acc_tags;
  logic [CW-1:0]     cnt_q, wp;
  logic [DISP_W-1:0] acc;

  // Flush clears are applied alongside resolve; a flushed dependent is already killed, so flush wins.
  assign clr         = (resolve_en ? resolve_id : '0) | (flush_en ? flush_mask : '0);
  assign branch_full = &live_q;
  assign in_rdy      = rst && (cnt_q <= ROOM_C) && !branch_full && !flush_en;
  assign acc         = in_vld & {DISP_W{in_rdy}};
  assign gnt_ext     = DEPTH'(out_gnt);

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      kill[i] = vld_q[i] && flush_en && (|(ent_q[i].mask & flush_mask));
  end

  assign gnt_hit = vld_q & ~kill & gnt_ext;

  genvar p;
  for (p = 0; p < ISSUE_W; p++) begin : g_out
    assign out_vld[p]                    = vld_q[p] & ~kill[p];
    assign out_des[p*REG_W +: REG_W]     = ent_q[p].des;
    assign out_s1[p*REG_W +: REG_W]      = ent_q[p].s1;
    assign out_s2[p*REG_W +: REG_W]      = ent_q[p].s2;
    assign out_op[p*OP_W +: OP_W]        = ent_q[p].op;
    assign out_ime[p*IMM_W +: IMM_W]     = ent_q[p].ime;
    assign out_branch[p]                 = ent_q[p].br;
    assign out_br_mask[p*NBR +: NBR]     = ent_q[p].mask;
  end

  // Survivors slide down in age order, then accepted lanes land behind them.
  always_comb begin
    ent_d    = ent_q;
    vld_d    = '0;
    wp       = '0;
    nw       = '0;
    run_mask = live_q & ~clr;
    live_d   = live_q & ~clr;
    acc_tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !kill[i] && !gnt_hit[i]) begin
        ent_d[wp[IW-1:0]]      = ent_q[i];
        ent_d[wp[IW-1:0]].mask = ent_q[i].mask & ~clr;
        vld_d[wp[IW-1:0]]      = 1'b1;
        wp                     = wp + 1'b1;
      end
    end
    for (int l = 0; l < DISP_W; l++) begin
      if (acc[l]) begin
        nw.des  = in_des[l*REG_W +: REG_W];
        nw.s1   = in_s1[l*REG_W +: REG_W];
        nw.s2   = in_s2[l*REG_W +: REG_W];
        nw.op   = in_op[l*OP_W +: OP_W];
        nw.ime  = in_ime[l*IMM_W +: IMM_W];
        nw.br   = in_br[l];
        nw.mask = run_mask;
        if (wp < DEPTH_C) begin
          ent_d[wp[IW-1:0]] = nw;
          vld_d[wp[IW-1:0]] = 1'b1;
        end
        wp = wp + 1'b1;
        if (in_br[l]) begin
          run_mask = run_mask | in_br_tag[l*NBR +: NBR];
          live_d   = live_d | in_br_tag[l*NBR +: NBR];
          acc_tags = acc_tags | in_br_tag[l*NBR +: NBR];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      live_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      live_q <= live_d;
      cnt_q  <= wp;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign count       = cnt_q;
  assign entry_full  = (cnt_q == DEPTH_C);
  assign entry_empty = (cnt_q == '0);

  a_tag_unique: assert property (@(posedge clk) disable iff (!rst) (acc_tags & live_q) == '0);

endmodule

// File: tb/tb_param_issue_queue.sv
// Directed vector bench for param_issue_queue: table of per-cycle stimulus with expected pre-edge outputs, plus a reset-mid-traffic sequence.
module tb_param_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_vld;
  logic [9:0]  in_des, in_s1, in_s2;
  logic [7:0]  in_op;
  logic [31:0] in_ime;
  logic [1:0]  in_br;
  logic [7:0]  in_br_tag;
  logic        in_rdy;
  logic [3:0]  out_vld;
  logic [19:0] out_des, out_s1, out_s2;
  logic [15:0] out_op;
  logic [63:0] out_ime;
  logic [3:0]  out_branch;
  logic [15:0] out_br_mask;
  logic [3:0]  out_gnt;
  logic        resolve_en, flush_en;
  logic [3:0]  resolve_id, flush_mask;
  logic [3:0]  count;
  logic        entry_full, entry_empty, branch_full;

  int tests = 0;
  int fails = 0;

  param_issue_queue dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2),
    .in_op(in_op), .in_ime(in_ime), .in_br(in_br), .in_br_tag(in_br_tag), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_des(out_des), .out_s1(out_s1), .out_s2(out_s2), .out_op(out_op),
    .out_ime(out_ime), .out_branch(out_branch), .out_br_mask(out_br_mask), .out_gnt(out_gnt),
    .resolve_en(resolve_en), .resolve_id(resolve_id), .flush_en(flush_en), .flush_mask(flush_mask),
    .count(count), .entry_full(entry_full), .entry_empty(entry_empty), .branch_full(branch_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] i0, i1;
    logic [1:0]  br;
    logic [3:0]  t0, t1, gnt;
    logic [4:0]  rs;      // {resolve_en, resolve_id}
    logic [4:0]  fl;      // {flush_en, flush_mask}
    logic [3:0]  e_vld;
    logic [3:0]  e_cnt;
    logic [3:0]  e_flg;   // {in_rdy, entry_full, entry_empty, branch_full}
    logic [63:0] e_ime;   // {port3..port0}
    logic [15:0] e_msk;   // {port3..port0}
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] vld, input logic [15:0] i0, input logic [15:0] i1,
                     input logic [1:0] br, input logic [3:0] t0, input logic [3:0] t1,
                     input logic [3:0] gnt, input logic [4:0] rs, input logic [4:0] fl,
                     input logic [3:0] e_vld, input logic [3:0] e_cnt, input logic [3:0] e_flg,
                     input logic [63:0] e_ime, input logic [15:0] e_msk);
    vec_t v;
    v.vld = vld; v.i0 = i0; v.i1 = i1; v.br = br; v.t0 = t0; v.t1 = t1; v.gnt = gnt;
    v.rs = rs; v.fl = fl; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_flg = e_flg;
    v.e_ime = e_ime; v.e_msk = e_msk;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [1:0] vld, input logic [15:0] i0, input logic [15:0] i1,
                       input logic [1:0] br, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [3:0] gnt, input logic [4:0] rs, input logic [4:0] fl);
    in_vld     = vld;
    in_ime     = {i1, i0};
    in_des     = {i1[4:0], i0[4:0]};
    in_s1      = '0;
    in_s2      = '0;
    in_op      = {i1[3:0], i0[3:0]};
    in_br      = br;
    in_br_tag  = {t1, t0};
    out_gnt    = gnt;
    resolve_en = rs[4];
    resolve_id = rs[3:0];
    flush_en   = fl[4];
    flush_mask = fl[3:0];
  endtask

  task automatic apply(input vec_t v, input int n);
    logic [63:0] m_ime;
    logic [15:0] m_msk;
    drive(v.vld, v.i0, v.i1, v.br, v.t0, v.t1, v.gnt, v.rs, v.fl);
    #4;
    m_ime = '0;
    m_msk = '0;
    for (int p = 0; p < 4; p++) begin
      if (v.e_vld[p]) begin
        m_ime[p*16 +: 16] = 16'hFFFF;
        m_msk[p*4 +: 4]   = 4'hF;
      end
    end
    chk($sformatf("r%0d out_vld", n), 64'(out_vld), 64'(v.e_vld));
    chk($sformatf("r%0d count", n), 64'(count), 64'(v.e_cnt));
    chk($sformatf("r%0d rdy/full/empty/bfull", n),
        64'({in_rdy, entry_full, entry_empty, branch_full}), 64'(v.e_flg));
    if (v.e_vld != 4'b0000) begin
      chk($sformatf("r%0d out_ime", n), out_ime & m_ime, v.e_ime & m_ime);
      chk($sformatf("r%0d out_br_mask", n), 64'(out_br_mask & m_msk), 64'(v.e_msk & m_msk));
    end
    if (v.e_vld[0]) chk($sformatf("r%0d out_des0", n), 64'(out_des[4:0]), 64'(v.e_ime[4:0]));
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b00, 16'h0, 16'h0, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);

    // Fill to full, then collapse with a non-contiguous grant and mixed dispatch/issue.
    add(2'b11, 16'h01, 16'h02, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0000, 4'd0, 4'b1010, 64'h0, 16'h0);
    add(2'b11, 16'h03, 16'h04, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0011, 4'd2, 4'b1000, 64'h0000_0000_0002_0001, 16'h0);
    add(2'b11, 16'h05, 16'h06, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b1111, 4'd4, 4'b1000, 64'h0004_0003_0002_0001, 16'h0);
    add(2'b11, 16'h07, 16'h08, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b1111, 4'd6, 4'b1000, 64'h0004_0003_0002_0001, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b1111, 5'h00, 5'h00, 4'b1111, 4'd8, 4'b0100, 64'h0004_0003_0002_0001, 16'h0);
    add(2'b11, 16'h09, 16'h0A, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b1111, 4'd4, 4'b1000, 64'h0008_0007_0006_0005, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0101, 5'h00, 5'h00, 4'b1111, 4'd6, 4'b1000, 64'h0008_0007_0006_0005, 16'h0);
    add(2'b10, 16'h00, 16'h0B, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b1111, 4'd4, 4'b1000, 64'h000A_0009_0008_0006, 16'h0);
    add(2'b01, 16'h0C, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0011, 5'h00, 5'h00, 4'b1111, 4'd5, 4'b1000, 64'h000A_0009_0008_0006, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b1111, 5'h00, 5'h00, 4'b1111, 4'd4, 4'b1000, 64'h000C_000B_000A_0009, 16'h0);
    // Branch dependence then flush of tag 0001.
    add(2'b11, 16'h20, 16'h21, 2'b01, 4'h1, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0000, 4'd0, 4'b1010, 64'h0, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0011, 4'd2, 4'b1000, 64'h0000_0000_0021_0020, 16'h0010);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h11, 4'b0001, 4'd2, 4'b0000, 64'h0000_0000_0000_0020, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0001, 5'h00, 5'h00, 4'b0001, 4'd1, 4'b1000, 64'h0000_0000_0000_0020, 16'h0);
    // Resolve and flush of the same tag: flush wins.
    add(2'b11, 16'h30, 16'h31, 2'b01, 4'h2, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0000, 4'd0, 4'b1010, 64'h0, 16'h0);
    add(2'b01, 16'h32, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0011, 4'd2, 4'b1000, 64'h0000_0000_0031_0030, 16'h0020);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h12, 5'h12, 4'b0001, 4'd3, 4'b0000, 64'h0000_0000_0000_0030, 16'h0);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0001, 5'h00, 5'h00, 4'b0001, 4'd1, 4'b1000, 64'h0000_0000_0000_0030, 16'h0);
    // All four tags live blocks dispatch; resolving 0100 reopens it and strips the bit.
    add(2'b11, 16'h40, 16'h41, 2'b11, 4'h1, 4'h2, 4'b0000, 5'h00, 5'h00, 4'b0000, 4'd0, 4'b1010, 64'h0, 16'h0);
    add(2'b11, 16'h42, 16'h43, 2'b01, 4'h4, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0011, 4'd2, 4'b1000, 64'h0000_0000_0041_0040, 16'h0010);
    add(2'b01, 16'h44, 16'h00, 2'b01, 4'h8, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b1111, 4'd4, 4'b1000, 64'h0043_0042_0041_0040, 16'h7310);
    add(2'b11, 16'h50, 16'h51, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h14, 5'h00, 4'b1111, 4'd5, 4'b0001, 64'h0043_0042_0041_0040, 16'h7310);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b1111, 5'h00, 5'h00, 4'b1111, 4'd5, 4'b1000, 64'h0043_0042_0041_0040, 16'h3310);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0001, 5'h00, 5'h00, 4'b0001, 4'd1, 4'b1000, 64'h0000_0000_0000_0044, 16'h0003);
    add(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'b0000, 5'h00, 5'h00, 4'b0000, 4'd0, 4'b1010, 64'h0, 16'h0);

    #2;
    chk("reset out_vld", 64'(out_vld), 64'h0);
    chk("reset count", 64'(count), 64'h0);
    chk("reset rdy/full/empty/bfull", 64'({in_rdy, entry_full, entry_empty, branch_full}), 64'b0010);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i], i);
    end

    // Reset mid-traffic with 5 entries and live tags 1011 outstanding.
    @(negedge clk); drive(2'b11, 16'h60, 16'h61, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    @(negedge clk); drive(2'b11, 16'h62, 16'h63, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    @(negedge clk); drive(2'b01, 16'h64, 16'h00, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    @(negedge clk); drive(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    #1;
    chk("pre-reset count", 64'(count), 64'd5);
    chk("pre-reset mask0", 64'(out_br_mask[3:0]), 64'hB);
    #2 rst = 1'b0;
    #1;
    chk("midreset out_vld", 64'(out_vld), 64'h0);
    chk("midreset count", 64'(count), 64'h0);
    chk("midreset rdy/full/empty/bfull", 64'({in_rdy, entry_full, entry_empty, branch_full}), 64'b0010);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b01, 16'h70, 16'h00, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    #1;
    chk("post-reset rdy", 64'(in_rdy), 64'h1);
    @(negedge clk);
    drive(2'b00, 16'h00, 16'h00, 2'b00, 4'h0, 4'h0, 4'h0, 5'h00, 5'h00);
    #1;
    chk("post-reset out_vld", 64'(out_vld), 64'b0001);
    chk("post-reset ime0", 64'(out_ime[15:0]), 64'h70);
    chk("post-reset mask0", 64'(out_br_mask[3:0]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
